// File: rtl/ann_to_snn_encoder_mc.sv
// ann_to_snn_encoder_mc: N-channel integrate-and-fire rate encoder, T spike vectors per activation frame.
// Optional leak enabled by defining ANN_SNN_ENC_LEAK_EN.  Rev 1.0
`default_nettype none

module ann_to_snn_encoder_mc #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int T          = 4,
  parameter int LEAK_SHIFT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N*DATA_WIDTH-1:0] in_data,
  input  logic [DATA_WIDTH-1:0]   in_threshold,
  input  logic                    in_mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [N-1:0]            spike_out,
  output logic                    spike_valid,
  input  logic                    spike_ready,
  output logic                    spike_last,
  output logic                    busy
);

  localparam int TW = $clog2(T);
  localparam int VW = DATA_WIDTH + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]              r_state;
  logic [N*DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0]   r_th;
  logic                    r_mode;
  logic [TW-1:0]           r_t;
  logic [VW-1:0]           r_v [N];
  logic [N-1:0]            r_spike;
  logic                    r_sv;
  logic                    r_last;

  logic [VW-1:0]           w_vl    [N];
  logic [VW-1:0]           w_s     [N];
  logic [VW-1:0]           w_vnext [N];
  logic [N-1:0]            w_fire;
  logic                    w_free;
  logic                    w_tlast;

  assign w_free  = !r_sv || spike_ready;
  assign w_tlast = (r_t == TW'(T - 1));

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ch
`ifdef ANN_SNN_ENC_LEAK_EN
      assign w_vl[gi] = r_v[gi] - (r_v[gi] >> LEAK_SHIFT);
`else
      if (LEAK_SHIFT > 0) begin : g_noleak
        assign w_vl[gi] = r_v[gi];
      end else begin : g_noleak_z
        assign w_vl[gi] = r_v[gi];
      end
`endif
      assign w_s[gi]     = w_vl[gi] + VW'(r_data[gi*DATA_WIDTH +: DATA_WIDTH]);
      assign w_fire[gi]  = (w_s[gi] >= {1'b0, r_th});
      assign w_vnext[gi] = w_fire[gi] ? (r_mode ? '0 : (w_s[gi] - {1'b0, r_th})) : w_s[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_th    <= '0;
      r_mode  <= 1'b0;
      r_t     <= '0;
      r_spike <= '0;
      r_sv    <= 1'b0;
      r_last  <= 1'b0;
      for (int i = 0; i < N; i++) r_v[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_sv && spike_ready) r_sv <= 1'b0;
          if (in_valid) begin
            r_data  <= in_data;
            // Zero threshold would fire on every step regardless of input; clamp to 1.
            r_th    <= (in_threshold == '0) ? DATA_WIDTH'(1) : in_threshold;
            r_mode  <= in_mode;
            r_t     <= '0;
            r_state <= S_RUN;
            for (int i = 0; i < N; i++) r_v[i] <= '0;
          end
        end
        S_RUN: begin
          if (w_free) begin
            for (int i = 0; i < N; i++) r_v[i] <= w_vnext[i];
            r_spike <= w_fire;
            r_sv    <= 1'b1;
            r_last  <= w_tlast;
            r_t     <= r_t + TW'(1);
            if (w_tlast) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (spike_ready) begin
            r_sv    <= 1'b0;
            r_last  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign spike_out   = r_spike;
  assign spike_valid = r_sv;
  assign spike_last  = r_last;

endmodule

`default_nettype wire

// File: tb/tb_ann_to_snn_encoder_mc.sv
// tb_ann_to_snn_encoder_mc: scoreboard bench for the multi-channel rate encoder.
`default_nettype none

module tb_ann_to_snn_encoder_mc;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int T  = 4;
  localparam int LS = 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N*DW-1:0] in_data = '0;
  logic [DW-1:0]   in_threshold = '0;
  logic            in_mode = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [N-1:0]    spike_out;
  logic            spike_valid;
  logic            spike_ready = 1'b1;
  logic            spike_last;
  logic            busy;

  ann_to_snn_encoder_mc #(.N(N), .DATA_WIDTH(DW), .T(T), .LEAK_SHIFT(LS)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_threshold(in_threshold),
    .in_mode(in_mode), .in_valid(in_valid), .in_ready(in_ready),
    .spike_out(spike_out), .spike_valid(spike_valid), .spike_ready(spike_ready),
    .spike_last(spike_last), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [N:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_pop   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N*DW-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [N*DW-1:0] r;
    r = '0;
    r[0*DW +: DW] = DW'(a);
    r[1*DW +: DW] = DW'(b);
    r[2*DW +: DW] = DW'(c);
    r[3*DW +: DW] = DW'(d);
    return r;
  endfunction

  // Reference integrate-and-fire model; potentials kept DW+1 bits wide.
  task automatic push_frame(input logic [N*DW-1:0] x, input logic [DW-1:0] th, input logic mode);
    int v[N];
    int th_e, mask, xi, vv, s;
    logic [N-1:0] bits;
    th_e = (th == 0) ? 1 : int'(th);
    mask = (1 << (DW + 1)) - 1;
    for (int i = 0; i < N; i++) v[i] = 0;
    for (int t = 0; t < T; t++) begin
      for (int i = 0; i < N; i++) begin
        xi = int'(x[i*DW +: DW]);
        vv = v[i];
`ifdef ANN_SNN_ENC_LEAK_EN
        vv = vv - (vv >> LS);
`endif
        s = (vv + xi) & mask;
        bits[i] = (s >= th_e);
        v[i] = bits[i] ? (mode ? 0 : s - th_e) : s;
      end
      exp_q.push_back({(t == T - 1), bits});
    end
  endtask

  // Output monitor: compares each handshaken vector and checks hold under backpressure.
  initial begin
    logic [N:0]   e;
    logic         stall;
    logic [N-1:0] p_out;
    logic         p_last;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("hold_out", 32'(spike_out), 32'(p_out));
          check("hold_last", 32'(spike_last), 32'(p_last));
          check("hold_valid", 32'(spike_valid), 32'd1);
        end
        if (spike_valid && spike_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_vec", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("spike", 32'(spike_out), 32'(e[N-1:0]));
            check("last", 32'(spike_last), 32'(e[N]));
            n_pop++;
          end
        end
        stall  = spike_valid && !spike_ready;
        p_out  = spike_out;
        p_last = spike_last;
      end
    end
  end

  task automatic send_frame(input logic [N*DW-1:0] x, input logic [DW-1:0] th, input logic mode);
    int k;
    k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1; k++;
    end
    check("accept_wait", 32'(in_ready), 32'd1);
    in_data = x; in_threshold = th; in_mode = mode; in_valid = 1'b1;
    push_frame(x, th, mode);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data = N*DW'($urandom);
    in_threshold = DW'($urandom);
    in_mode = ~mode;
    check("busy_run", 32'(busy), 32'd1);
    check("in_ready_run", 32'(in_ready), 32'd0);
    check("valid_pre", 32'(spike_valid), 32'd0);
    @(posedge clk); #1;
    check("valid_first", 32'(spike_valid), 32'd1);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!(exp_q.size() == 0 && in_ready) && k < 100) begin
      @(posedge clk); #1; k++;
    end
    check("frame_done", 32'(exp_q.size() == 0 && in_ready), 32'd1);
  endtask

  task automatic wait_pops(input int target);
    int k;
    k = 0;
    while (n_pop < target && k < 50) begin
      @(negedge clk); k++;
    end
    check("pop_wait", 32'(n_pop >= target), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(spike_valid), 32'd0);
    check("rst_out", 32'(spike_out), 32'd0);
    check("rst_last", 32'(spike_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Soft reset, mixed activations; exactly T consecutive vectors, then idle.
    send_frame(pack4(6, 5, 8, 1), 8'd8, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      check("valid_run", 32'(spike_valid), 32'd1);
    end
    @(posedge clk); #1;
    check("valid_end", 32'(spike_valid), 32'd0);
    check("in_ready_end", 32'(in_ready), 32'd1);
    wait_done();

    // Hard reset and zero-threshold corners.
    send_frame(pack4(6, 0, 9, 3), 8'd8, 1'b1);
    wait_done();
    send_frame(pack4(0, 0, 0, 0), 8'd0, 1'b0);
    wait_done();
    send_frame(pack4(1, 1, 1, 1), 8'd0, 1'b0);
    wait_done();

    // Backpressure after vector 1.
    base = n_pop;
    send_frame(pack4(6, 5, 8, 1), 8'd8, 1'b0);
    wait_pops(base + 2);
    @(posedge clk); #1;
    spike_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("in_ready_stall", 32'(in_ready), 32'd0);
    end
    spike_ready = 1'b1;
    wait_done();

    // Width corners.
    send_frame(pack4(255, 255, 255, 255), 8'd8, 1'b0);
    wait_done();
    send_frame(pack4(255, 255, 255, 255), 8'd255, 1'b0);
    wait_done();

    // Reset mid-frame, then a clean frame.
    base = n_pop;
    send_frame(pack4(6, 5, 8, 1), 8'd8, 1'b0);
    wait_pops(base + 2);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(spike_valid), 32'd0);
    check("arst_out", 32'(spike_out), 32'd0);
    check("arst_last", 32'(spike_last), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd1);
    send_frame(pack4(8, 8, 8, 8), 8'd8, 1'b0);
    wait_done();

    // A few random frames, soft and hard.
    for (int r = 0; r < 4; r++) begin
      send_frame(N*DW'({$urandom, $urandom}), DW'($urandom_range(0, 40)), 1'(r));
      wait_done();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
